// File: rtl/int_seq_pkg.sv
// Shared definitions for the interrupt entry/exit sequencer:
// FSM state encodings and register map addresses.
package int_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_ENTER = 3'd2,
    ST_ISR   = 3'd3,
    ST_EXIT  = 3'd4
  } state_e;

  localparam logic [11:0] ADDR_STAT = 12'h3;
  localparam logic [11:0] ADDR_EPC  = 12'h4;
  localparam logic [11:0] ADDR_VEC  = 12'h5;

  localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/int_seq_if.sv
// Bundles the register bus, interrupt handshake and core PC-control signals.
interface int_seq_if #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 13
);

  logic [DW-1:0] din;
  logic [AW-1:0] addr;
  logic          we;
  logic [DW-1:0] dout;
  logic          int_vld;
  logic          int_rdy;
  logic          insn_done;
  logic [AW-1:0] pc_next;
  logic          reti;
  logic          pc_load;
  logic [AW-1:0] pc_o;
  logic          stall;

  modport master (
    output din, addr, we, int_vld, insn_done, pc_next, reti,
    input  dout, int_rdy, pc_load, pc_o, stall
  );

  modport slave (
    input  din, addr, we, int_vld, insn_done, pc_next, reti,
    output dout, int_rdy, pc_load, pc_o, stall
  );

endinterface

// File: rtl/int_seq.sv
// Interrupt sequencer: waits for an instruction boundary, saves the return PC,
// forces the core to the ISR vector, and restores the saved PC on reti.
module int_seq
  import int_seq_pkg::*;
#(
  parameter int unsigned   DW      = 16,
  parameter int unsigned   AW      = 13,
  parameter logic [AW-1:0] VEC_RST = 13'h0010
) (
  input  logic      clk,
  input  logic      rst,
  int_seq_if.slave  bus
);

  state_e            state_q, state_d;
  logic [AW-1:0]     epc_q, epc_d;
  logic [AW-1:0]     vec_q, vec_d;
  logic              lost_q, lost_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]     dout_q, dout_d;

  logic              stat_wr, epc_wr, vec_wr;
  logic              force_pc;
  logic [DW-1:0]     stat_val;
  logic              unused_din;

  assign stat_wr = bus.we && (bus.addr == AW'(ADDR_STAT));
  assign epc_wr  = bus.we && (bus.addr == AW'(ADDR_EPC));
  assign vec_wr  = bus.we && (bus.addr == AW'(ADDR_VEC));

  assign stat_val   = DW'({cnt_q, 2'b00, err_q, lost_q, 1'b0, state_q});
  assign unused_din = ^bus.din;

  // State register and all architectural flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      epc_q   <= '0;
      vec_q   <= VEC_RST;
      lost_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
      vec_q   <= vec_d;
      lost_q  <= lost_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
    end
  end

  // Next-state, register updates and read mux
  always_comb begin
    state_d = state_q;
    epc_d   = epc_q;
    vec_d   = vec_q;
    lost_d  = lost_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;

    unique case (state_q)
      ST_IDLE:  if (bus.int_vld)   state_d = ST_WAIT;
      ST_WAIT:  if (bus.insn_done) state_d = ST_ENTER;
      ST_ENTER:                    state_d = ST_ISR;
      ST_ISR:   if (bus.reti)      state_d = ST_EXIT;
      ST_EXIT:                     state_d = ST_IDLE;
      default:                     state_d = ST_IDLE;
    endcase

    if (epc_wr) epc_d = bus.din[AW-1:0];
    if (vec_wr) vec_d = bus.din[AW-1:0];
    // Boundary capture of the return PC overrides a coincident bus write
    if (state_q == ST_WAIT && bus.insn_done) epc_d = bus.pc_next;

    if (stat_wr) begin
      if (bus.din[4])  lost_d = 1'b0;
      if (bus.din[5])  err_d  = 1'b0;
      if (bus.din[15]) cnt_d  = '0;
    end
    // Sticky sets come after the W1C so a same-cycle event is never lost
    if (bus.int_vld && state_q != ST_IDLE) lost_d = 1'b1;
    if (bus.reti && state_q != ST_ISR)     err_d  = 1'b1;

    if (state_q == ST_ENTER && cnt_d != '1) cnt_d = cnt_d + CNT_W'(1);

    if (!bus.we) begin
      if (bus.addr == AW'(ADDR_STAT))     dout_d = stat_val;
      else if (bus.addr == AW'(ADDR_EPC)) dout_d = DW'(epc_q);
      else if (bus.addr == AW'(ADDR_VEC)) dout_d = DW'(vec_q);
      else                                dout_d = '0;
    end
  end

  // PC force is decoded from state; a reset in the forcing cycle suppresses it
  assign force_pc    = !rst && (state_q == ST_ENTER || state_q == ST_EXIT);
  assign bus.pc_load = force_pc;
  assign bus.stall   = force_pc;
  assign bus.pc_o    = !force_pc             ? '0    :
                       (state_q == ST_ENTER) ? vec_q : epc_q;
  assign bus.int_rdy = (state_q == ST_IDLE);
  assign bus.dout    = dout_q;

endmodule

// File: tb/tb_int_seq.sv
// Directed-vector bench for int_seq: entry/exit sequencing, sticky flags,
// register access, counter saturation and reset during a PC force.
module tb_int_seq;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_bad;

  int_seq_if #(.DW(16), .AW(13)) bif ();

  int_seq #(.DW(16), .AW(13), .VEC_RST(13'h0010)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [12:0] a, input logic [15:0] exp, input string tag);
    bif.addr = a;
    bif.we   = 1'b0;
    tick();
    chk_val(tag, 32'(bif.dout), 32'(exp));
  endtask

  task automatic wr(input logic [12:0] a, input logic [15:0] d);
    bif.addr = a;
    bif.din  = d;
    bif.we   = 1'b1;
    tick();
    bif.we   = 1'b0;
  endtask

  // One full interrupt round trip, ending back in IDLE
  task automatic round_trip();
    bif.insn_done = 1'b1;
    bif.int_vld   = 1'b1;
    tick();
    bif.int_vld   = 1'b0;
    tick();
    tick();
    bif.reti = 1'b1;
    tick();
    bif.reti = 1'b0;
    tick();
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    rst = 1'b1;
    bif.din = '0; bif.addr = 13'h7; bif.we = 1'b0;
    bif.int_vld = 1'b0; bif.insn_done = 1'b0; bif.pc_next = '0; bif.reti = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    chk_val("rst_int_rdy", 32'(bif.int_rdy), 32'd1);
    chk_val("rst_pc_load", 32'(bif.pc_load), 32'd0);
    chk_val("rst_pc_o",    32'(bif.pc_o),    32'd0);
    chk_val("rst_stall",   32'(bif.stall),   32'd0);
    chk_val("rst_dout",    32'(bif.dout),    32'd0);
    rd(13'h3, 16'h0000, "rst_stat");
    rd(13'h5, 16'h0010, "rst_vec");
    rd(13'h4, 16'h0000, "rst_epc");

    // Entry with instruction boundary already present
    bif.insn_done = 1'b1;
    bif.pc_next   = 13'h0123;
    bif.int_vld   = 1'b1;
    tick();
    bif.int_vld = 1'b0;
    chk_val("wait_int_rdy", 32'(bif.int_rdy), 32'd0);
    chk_val("wait_pc_load", 32'(bif.pc_load), 32'd0);
    tick();
    chk_val("enter_pc_load", 32'(bif.pc_load), 32'd1);
    chk_val("enter_pc_o",    32'(bif.pc_o),    32'h0010);
    chk_val("enter_stall",   32'(bif.stall),   32'd1);
    tick();
    chk_val("isr_pc_load", 32'(bif.pc_load), 32'd0);
    chk_val("isr_pc_o",    32'(bif.pc_o),    32'd0);
    chk_val("isr_stall",   32'(bif.stall),   32'd0);
    rd(13'h4, 16'h0123, "epc_capture");
    rd(13'h3, 16'h0103, "stat_isr");

    // Interrupt while busy sets LOST without moving the FSM
    bif.int_vld = 1'b1;
    tick();
    bif.int_vld = 1'b0;
    rd(13'h3, 16'h0113, "stat_lost");
    wr(13'h3, 16'h0010);
    rd(13'h3, 16'h0103, "stat_lost_clr");

    // Return from interrupt
    bif.reti = 1'b1;
    tick();
    bif.reti = 1'b0;
    chk_val("exit_pc_load", 32'(bif.pc_load), 32'd1);
    chk_val("exit_pc_o",    32'(bif.pc_o),    32'h0123);
    chk_val("exit_stall",   32'(bif.stall),   32'd1);
    chk_val("exit_int_rdy", 32'(bif.int_rdy), 32'd0);
    tick();
    chk_val("idle_int_rdy", 32'(bif.int_rdy), 32'd1);
    chk_val("idle_pc_load", 32'(bif.pc_load), 32'd0);

    // VEC write, read-data hold on writes, unmapped read
    wr(13'h5, 16'h0200);
    rd(13'h5, 16'h0200, "vec_rd");
    bif.addr = 13'h7; bif.din = 16'h1234; bif.we = 1'b1;
    tick();
    bif.we = 1'b0;
    chk_val("dout_hold_we", 32'(bif.dout), 32'h0200);
    rd(13'h7, 16'h0000, "rd_unmapped");

    // New vector used on entry; EPC written in the reti cycle used on exit
    bif.insn_done = 1'b1;
    bif.pc_next   = 13'h0777;
    bif.int_vld   = 1'b1;
    tick();
    bif.int_vld = 1'b0;
    tick();
    chk_val("enter2_pc_o", 32'(bif.pc_o), 32'h0200);
    tick();
    bif.reti = 1'b1; bif.we = 1'b1; bif.addr = 13'h4; bif.din = 16'h0456;
    tick();
    bif.reti = 1'b0; bif.we = 1'b0;
    chk_val("exit2_pc_load", 32'(bif.pc_load), 32'd1);
    chk_val("exit2_pc_o",    32'(bif.pc_o),    32'h0456);
    tick();

    // WAIT holds without a boundary; capture beats a coincident EPC write
    bif.insn_done = 1'b0;
    bif.int_vld   = 1'b1;
    tick();
    bif.int_vld = 1'b0;
    tick();
    chk_val("wait_hold_pc_load", 32'(bif.pc_load), 32'd0);
    rd(13'h3, 16'h0201, "stat_wait");
    bif.we = 1'b1; bif.addr = 13'h4; bif.din = 16'h0AAA;
    bif.insn_done = 1'b1; bif.pc_next = 13'h0BBB;
    tick();
    bif.we = 1'b0;
    chk_val("enter3_pc_o", 32'(bif.pc_o), 32'h0200);
    tick();
    rd(13'h4, 16'h0BBB, "epc_collision");
    bif.reti = 1'b1;
    tick();
    bif.reti = 1'b0;
    chk_val("exit3_pc_o", 32'(bif.pc_o), 32'h0BBB);
    tick();

    // Counter saturation
    for (int i = 0; i < 256; i++) round_trip();
    rd(13'h3, 16'hFF00, "cnt_sat");

    // reti in IDLE sets ERR; a same-cycle W1C loses to the set
    bif.reti = 1'b1; bif.we = 1'b1; bif.addr = 13'h3; bif.din = 16'h0020;
    tick();
    bif.reti = 1'b0; bif.we = 1'b0;
    rd(13'h3, 16'hFF20, "err_set_wins");
    wr(13'h3, 16'h0020);
    rd(13'h3, 16'hFF00, "err_clr");
    wr(13'h3, 16'h8000);
    rd(13'h3, 16'h0000, "cnt_clr");

    // Reset in the ENTER cycle aborts the PC force
    bif.insn_done = 1'b1;
    bif.int_vld   = 1'b1;
    tick();
    bif.int_vld = 1'b0;
    tick();
    chk_val("enter4_pc_load", 32'(bif.pc_load), 32'd1);
    rst = 1'b1;
    #1;
    chk_val("abort_pc_load", 32'(bif.pc_load), 32'd0);
    chk_val("abort_stall",   32'(bif.stall),   32'd0);
    chk_val("abort_pc_o",    32'(bif.pc_o),    32'd0);
    tick();
    rst = 1'b0;
    chk_val("abort_int_rdy",  32'(bif.int_rdy), 32'd1);
    chk_val("abort_pc_load2", 32'(bif.pc_load), 32'd0);
    rd(13'h3, 16'h0000, "abort_stat");
    rd(13'h5, 16'h0010, "abort_vec");
    rd(13'h4, 16'h0000, "abort_epc");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/int_seq.md
INT_SEQ -- requirements
Module: int_seq

Interface
REQ-001 Parameter DW, default 16, bus data width.
REQ-002 Parameter AW, default 13, bus address and PC width.
REQ-003 Parameter VEC_RST, default 13'h0010, reset value of the ISR entry vector.
REQ-004 clk  input  1  clock; all logic rising-edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 din  input  DW  bus write data.
REQ-007 addr  input  AW  bus address.
REQ-008 we  input  1  bus write enable, high active.
REQ-009 dout  output  DW  registered bus read data.
REQ-010 int_vld  input  1  interrupt request from interrupt manager.
REQ-011 int_rdy  output  1  sequencer accepts a new interrupt; to interrupt manager.
REQ-012 insn_done  input  1  core at instruction boundary this cycle.
REQ-013 pc_next  input  AW  core next-PC at boundary.
REQ-014 reti  input  1  core retired return-from-interrupt, 1-cycle pulse.
REQ-015 pc_load  output  1  force core PC, 1-cycle pulse.
REQ-016 pc_o  output  AW  PC value forced when pc_load=1.
REQ-017 stall  output  1  hold core fetch.

Function
REQ-018 FSM states SHALL be IDLE, WAIT, ENTER, ISR, EXIT.
REQ-019 IDLE: int_rdy=1; int_vld=1 -> WAIT next cycle.
REQ-020 WAIT: int_rdy=0; on insn_done=1, EPC<=pc_next, -> ENTER.
REQ-021 ENTER: pc_load=1, pc_o=VEC, stall=1, CNT increments; -> ISR unconditionally (1 cycle).
REQ-022 ISR: int_rdy=0; reti=1 -> EXIT.
REQ-023 EXIT: pc_load=1, pc_o=EPC, stall=1; -> IDLE; int_rdy=1 the following cycle.
REQ-024 pc_load and stall SHALL be 0 in IDLE, WAIT, ISR; pc_o=0 when pc_load=0.
REQ-025 Latency int_vld to pc_load SHALL be 2 cycles when insn_done is already 1 in WAIT.
REQ-026 int_vld=1 in any state other than IDLE SHALL set sticky LOST and SHALL NOT change state.
REQ-027 reti outside ISR SHALL be ignored and set sticky ERR.
REQ-028 Register map: 12'h3 STAT (RO except W1C), 12'h4 EPC (RW), 12'h5 VEC (RW).
REQ-029 STAT: [2:0] state code (IDLE=0, WAIT=1, ENTER=2, ISR=3, EXIT=4), [4] LOST, [5] ERR, [15:8] CNT.
REQ-030 Writing 1 to STAT[4]/[5] SHALL clear LOST/ERR; a same-cycle set SHALL win over clear.
REQ-031 CNT SHALL be 8-bit, saturating at 8'hFF; writing STAT with din[15]=1 SHALL clear CNT.
REQ-032 Bus write to EPC SHALL take effect next cycle; a write coincident with the WAIT capture SHALL lose to the capture.
REQ-033 Write to EPC in the reti cycle SHALL be the value used by EXIT.
REQ-034 Reads SHALL return the register one cycle after addr with we=0; unmapped or we=1 cycles SHALL leave dout at 0 for unmapped, unchanged for we=1.

Reset
REQ-035 rst SHALL force IDLE, EPC=0, VEC=VEC_RST, LOST=ERR=0, CNT=0, dout=0.
REQ-036 Outputs after reset: int_rdy=1, pc_load=0, pc_o=0, stall=0.
REQ-037 rst during ENTER or EXIT SHALL abort the pulse in that cycle; no PC force issued.

Structure
REQ-038 Shared package SHALL hold state encodings and register addresses 12'h3-12'h5.
REQ-039 Single module; no sub-module.

Verification
REQ-040 IDLE, int_vld pulse, insn_done=1, pc_next=13'h0123 -> pc_load at cycle+2, pc_o=13'h0010, EPC=13'h0123.
REQ-041 In ISR, reti pulse -> next cycle pc_load=1, pc_o=13'h0123; int_rdy=1 one cycle later.
REQ-042 int_vld during ISR -> STAT[4]=1, state stays 3; write STAT=16'h0010 -> STAT[4]=0.
REQ-043 Write VEC=13'h0200, EPC=13'h0456 with reti -> entry uses 13'h0200, exit pc_o=13'h0456.
REQ-044 256 complete entries -> STAT[15:8]=8'hFF; reti in IDLE -> STAT[5]=1.
REQ-045 rst asserted in ENTER cycle -> pc_load=0, state IDLE, int_rdy=1 next cycle.
